// File: rtl/spi_arbiter.sv
// spi_arbiter: shares one spi_controller between NUM_REQ requesters.
//
// Each requester offers one SPI transaction (mode + 16-bit payload) with a
// valid/ready handshake. The arbiter grants round-robin, latches the winning
// transaction, drives it into the controller, waits for the controller to
// finish, and returns a one-cycle rsp_valid pulse plus the 24-bit read result
// to the winner. Every transaction is followed by a csb-high gap.
//
// Optional build macro: SPI_ARB_LOCK_EN adds req_lock so that an owner can
// keep the bus across consecutive transactions (e.g. display command + data).
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   req_valid/mode/data       per-requester transaction request
//   req_lock                  per-requester bus lock (SPI_ARB_LOCK_EN only)
//   req_ready                 one-hot accept, combinational in S_IDLE
//   rsp_valid, rsp_data       one-hot completion pulse, read result
//   grant, busy               current owner (one-hot), arbiter not idle
//   spi_mode, spi_i_valid,
//   spi_i_data                controller input handshake (latched request)
//   spi_i_ready, spi_o_valid,
//   spi_o_data                controller status and read data
//
// state        | meaning
// -------------+-------------------------------------------------------------
// S_IDLE       | select winner, req_ready to it, latch request on the edge
// S_ISSUE      | spi_i_valid high until the controller takes it
// S_WAIT_START | wait for the controller to leave idle (spi_i_ready low)
// S_BUSY       | wait for the controller to return to idle, then respond
// S_GAP        | csb-high gap, max(GAP_CYCLES,1) cycles, grant cleared

package spi_arbiter_pkg;
  typedef enum logic [2:0] {
    WRITE_8         = 3'd0,
    WRITE_16        = 3'd1,
    WRITE_8_READ_8  = 3'd2,
    WRITE_8_READ_16 = 3'd3,
    WRITE_8_READ_24 = 3'd4
  } spi_transaction_t;
endpackage

module spi_arbiter
  import spi_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int GAP_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  spi_transaction_t       req_mode [NUM_REQ],
  input  logic [15:0]            req_data [NUM_REQ],
`ifdef SPI_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]     req_lock,
`endif
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  output logic [23:0]            rsp_data,
  output logic [NUM_REQ-1:0]     grant,
  output logic                   busy,
  output spi_transaction_t       spi_mode,
  output logic                   spi_i_valid,
  output logic [15:0]            spi_i_data,
  input  logic                   spi_i_ready,
  input  logic                   spi_o_valid,
  input  logic [23:0]            spi_o_data
);

  localparam int IW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  generate
    if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
      $error("spi_arbiter: NUM_REQ must be in 2..8");
    end
    if (GAP_CYCLES < 0) begin : g_bad_gap
      $error("spi_arbiter: GAP_CYCLES must not be negative");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ISSUE      = 3'd1,
    S_WAIT_START = 3'd2,
    S_BUSY       = 3'd3,
    S_GAP        = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [IW-1:0]     last_grant;
  logic [IW-1:0]     win;
  logic [IW-1:0]     cand;
  logic              found;
  logic [NUM_REQ-1:0] win_mask;
  logic [NUM_REQ-1:0] req_elig;
  logic [GW-1:0]     gap_cnt;
  spi_transaction_t  mode_q;
  logic [15:0]       data_q;
  logic              is_read;

`ifdef SPI_ARB_LOCK_EN
  logic              lock_q;

  // While locked only the previous owner is eligible.
  assign req_elig = lock_q ? (req_valid & (NUM_REQ'(1) << last_grant)) : req_valid;
`else
  assign req_elig = req_valid;
`endif

  // Round-robin search starting just after the last owner; the last owner
  // itself is checked last so it cannot starve anyone.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = IW'((int'(last_grant) + k) % NUM_REQ);
      if (!found && req_elig[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  assign win_mask = NUM_REQ'(1) << win;
  assign is_read  = (mode_q == WRITE_8_READ_8) || (mode_q == WRITE_8_READ_16) ||
                    (mode_q == WRITE_8_READ_24);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready   = '0;
    spi_i_valid = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          req_ready = win_mask;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        spi_i_valid = 1'b1;
        if (spi_i_ready) state_d = S_WAIT_START;
      end
      S_WAIT_START: begin
        if (!spi_i_ready) state_d = S_BUSY;
      end
      S_BUSY: begin
        if (spi_i_ready) state_d = S_GAP;
      end
      S_GAP: begin
        if (gap_cnt == '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign spi_mode   = mode_q;
  assign spi_i_data = data_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_grant <= IW'(NUM_REQ - 1);
      grant      <= '0;
      mode_q     <= WRITE_8;
      data_q     <= '0;
      rsp_valid  <= '0;
      rsp_data   <= '0;
      gap_cnt    <= '0;
    end else begin
      rsp_valid <= '0;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            mode_q     <= req_mode[win];
            data_q     <= req_data[win];
            grant      <= win_mask;
            last_grant <= win;
          end
        end
        S_BUSY: begin
          if (spi_i_ready) begin
            rsp_valid <= grant;
            rsp_data  <= (is_read && spi_o_valid) ? spi_o_data : 24'h0;
            grant     <= '0;
            gap_cnt   <= GW'(GAP_LOAD);
          end
        end
        S_GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SPI_ARB_LOCK_EN
  // Lock is sampled from the owner at the end of the gap; it drops as soon
  // as the owner is idle-without-request or requests with lock released.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lock_q <= 1'b0;
    end else begin
      case (state_q)
        S_GAP: begin
          if (gap_cnt == '0) lock_q <= req_lock[last_grant];
        end
        S_IDLE: begin
          if (lock_q && (!req_valid[last_grant] || !req_lock[last_grant]))
            lock_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end
`endif

endmodule

// File: tb/tb_spi_arbiter.sv
module tb_spi_arbiter;
  import spi_arbiter_pkg::*;

  localparam int N   = 2;
  localparam int GAP = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid;
  spi_transaction_t req_mode [N];
  logic [15:0]      req_data [N];
`ifdef SPI_ARB_LOCK_EN
  logic [N-1:0]     req_lock;
`endif
  logic [N-1:0]     req_ready;
  logic [N-1:0]     rsp_valid;
  logic [23:0]      rsp_data;
  logic [N-1:0]     grant;
  logic             busy;
  spi_transaction_t spi_mode;
  logic             spi_i_valid;
  logic [15:0]      spi_i_data;
  logic             spi_i_ready;
  logic             spi_o_valid;
  logic [23:0]      spi_o_data;

  always #5 clk = ~clk;

  spi_arbiter #(.NUM_REQ(N), .GAP_CYCLES(GAP)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_mode    (req_mode),
    .req_data    (req_data),
`ifdef SPI_ARB_LOCK_EN
    .req_lock    (req_lock),
`endif
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .grant       (grant),
    .busy        (busy),
    .spi_mode    (spi_mode),
    .spi_i_valid (spi_i_valid),
    .spi_i_data  (spi_i_data),
    .spi_i_ready (spi_i_ready),
    .spi_o_valid (spi_o_valid),
    .spi_o_data  (spi_o_data)
  );

  // Controller model: idle with i_ready high; takes i_valid, drops i_ready,
  // works ctl_len+1 cycles, then returns to ready with a 1-cycle o_valid.
  // o_valid/o_data are returned for writes too, so the arbiter must gate.
  int          ctl_len   = 3;
  logic [23:0] ctl_rdata = 24'h00ABCD;
  logic        ctl_busy;
  int          ctl_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      ctl_busy    <= 1'b0;
      ctl_cnt     <= 0;
      spi_i_ready <= 1'b1;
      spi_o_valid <= 1'b0;
      spi_o_data  <= 24'h0;
    end else begin
      spi_o_valid <= 1'b0;
      if (!ctl_busy) begin
        if (spi_i_valid && spi_i_ready) begin
          ctl_busy    <= 1'b1;
          spi_i_ready <= 1'b0;
          ctl_cnt     <= ctl_len;
        end
      end else if (ctl_cnt == 0) begin
        ctl_busy    <= 1'b0;
        spi_i_ready <= 1'b1;
        spi_o_valid <= 1'b1;
        spi_o_data  <= ctl_rdata;
      end else begin
        ctl_cnt <= ctl_cnt - 1;
      end
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (req_ready != '0) break;
      @(negedge clk);
    end
    check_val(tag, 32'(req_ready != '0), 32'd1);
  endtask

  task automatic wait_rsp(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (rsp_valid != '0) break;
      @(negedge clk);
    end
    check_val(tag, 32'(rsp_valid != '0), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 100; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    check_val(tag, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] exp_g;
    int           gap_len;
    logic         gap_ok;
    logic         seen;

    rst       = 1'b0;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin
      req_mode[i] = WRITE_8;
      req_data[i] = 16'h0;
    end
`ifdef SPI_ARB_LOCK_EN
    req_lock = '0;
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check_val("rst_req_ready",  32'(req_ready),   32'h0);
    check_val("rst_rsp_valid",  32'(rsp_valid),   32'h0);
    check_val("rst_grant",      32'(grant),       32'h0);
    check_val("rst_busy",       32'(busy),        32'h0);
    check_val("rst_i_valid",    32'(spi_i_valid), 32'h0);
    check_val("rst_rsp_data",   32'(rsp_data),    32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Single WRITE_8 from requester 0
    req_mode[0]  = WRITE_8;
    req_data[0]  = 16'h002C;
    req_valid    = 2'b01;
    #1;
    check_val("t1_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    check_val("t1_grant",   32'(grant),       32'h1);
    check_val("t1_i_valid", 32'(spi_i_valid), 32'h1);
    check_val("t1_i_data",  32'(spi_i_data),  32'h002C);
    check_val("t1_mode",    32'(spi_mode),    32'(WRITE_8));
    check_val("t1_busy",    32'(busy),        32'h1);
    @(negedge clk);
    check_val("t1_i_valid_1cyc", 32'(spi_i_valid), 32'h0);
    wait_rsp("t1_rsp_seen");
    check_val("t1_rsp_valid", 32'(rsp_valid), 32'h1);
    check_val("t1_rsp_data",  32'(rsp_data),  32'h0);
    @(negedge clk);
    check_val("t1_rsp_pulse", 32'(rsp_valid), 32'h0);
    check_val("t1_gap_grant", 32'(grant),     32'h0);
    wait_idle("t1_idle");

    // Round robin with both requesting, read on requester 1, gap length
    do_reset();
    req_mode[0] = WRITE_8;
    req_data[0] = 16'h1234;
    req_mode[1] = WRITE_8_READ_16;
    req_data[1] = 16'h8100;
    ctl_rdata   = 24'h00ABCD;
    req_valid   = 2'b11;
    #1;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t % 2 == 0) ? 2'b01 : 2'b10;
      wait_ready("t2_ready_seen");
      check_val("t2_req_ready", 32'(req_ready), 32'(exp_g));
      @(negedge clk);
      check_val("t2_grant",  32'(grant),      32'(exp_g));
      check_val("t2_i_data", 32'(spi_i_data), (t % 2 == 0) ? 32'h1234 : 32'h8100);
      wait_rsp("t2_rsp_seen");
      check_val("t2_rsp_valid", 32'(rsp_valid), 32'(exp_g));
      check_val("t2_rsp_data",  32'(rsp_data),  (t % 2 == 0) ? 32'h0 : 32'h00ABCD);
      if (t < 3) begin
        gap_len = 1;
        gap_ok  = busy && (grant == '0);
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (req_ready != '0) break;
          if (!busy || grant != '0) gap_ok = 1'b0;
          gap_len++;
        end
        check_val("t2_gap_len", 32'(gap_len), 32'(GAP));
        check_val("t2_gap_ok",  32'(gap_ok),  32'h1);
      end else begin
        req_valid = 2'b00;
      end
    end
    wait_idle("t2_idle");

    // Reset during S_BUSY aborts; requester 0 wins first afterwards
    ctl_len     = 6;
    req_mode[0] = WRITE_8;
    req_data[0] = 16'hBEEF;
    req_valid   = 2'b01;
    #1;
    wait_ready("t4_ready_seen");
    check_val("t4_req_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    repeat (3) @(negedge clk);
    check_val("t4_busy_pre", 32'(busy),  32'h1);
    check_val("t4_grant_pre", 32'(grant), 32'h1);
    rst = 1'b0;
    #1;
    check_val("t4_rst_grant",    32'(grant),       32'h0);
    check_val("t4_rst_busy",     32'(busy),        32'h0);
    check_val("t4_rst_rsp_data", 32'(rsp_data),    32'h0);
    check_val("t4_rst_i_valid",  32'(spi_i_valid), 32'h0);
    check_val("t4_rst_i_data",   32'(spi_i_data),  32'h0);
    check_val("t4_rst_mode",     32'(spi_mode),    32'h0);
    check_val("t4_rst_rsp",      32'(rsp_valid),   32'h0);
    @(negedge clk);
    rst     = 1'b1;
    ctl_len = 3;
    seen    = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid != '0) seen = 1'b1;
    end
    check_val("t4_no_rsp_after_rst", 32'(seen), 32'h0);
    req_valid = 2'b11;
    #1;
    check_val("t4_first_after_rst", 32'(req_ready), 32'h1);
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp("t4_rsp_seen");
    check_val("t4_rsp_valid", 32'(rsp_valid), 32'h1);
    wait_idle("t4_idle");

`ifdef SPI_ARB_LOCK_EN
    // Requester 0 holds the lock for three transactions while 1 waits
    do_reset();
    req_lock  = 2'b01;
    req_valid = 2'b11;
    #1;
    for (int t = 0; t < 4; t++) begin
      exp_g = (t < 3) ? 2'b01 : 2'b10;
      wait_ready("lk_ready_seen");
      check_val("lk_req_ready", 32'(req_ready), 32'(exp_g));
      if (t == 2) req_lock = 2'b00;
      @(negedge clk);
      wait_rsp("lk_rsp_seen");
      check_val("lk_rsp_valid", 32'(rsp_valid), 32'(exp_g));
      if (t == 3) req_valid = 2'b00;
      @(negedge clk);
    end
    wait_idle("lk_idle");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
